// File: rtl/rf_wb_ctrl.sv
// Write-back controller: round-robin arbitration of two write-back requesters onto
// the single register-file write port, plus a per-register busy scoreboard for RAW stalls.
module rf_wb_ctrl #(
  parameter int unsigned NUM_REG = 32,
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned DATA_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alloc_v,
  input  logic [ADDR_W-1:0] alloc_rd,
  input  logic              a_valid,
  input  logic [ADDR_W-1:0] a_rd,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [ADDR_W-1:0] b_rd,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  output logic [ADDR_W-1:0] rd,
  output logic              write_e,
  output logic [DATA_W-1:0] write_d,
  input  logic [ADDR_W-1:0] reg_s1,
  input  logic [ADDR_W-1:0] reg_s2,
  output logic              stall,
  output logic [NUM_REG-1:0] busy,
  output logic              err
);

  typedef enum logic {
    PRIO_A = 1'b0,
    PRIO_B = 1'b1
  } prio_e;

  prio_e               prio_q, prio_d;
  logic [NUM_REG-1:0]  busy_q, busy_d;
  logic                err_q, err_d;

  logic                gnt_a, gnt_b, gnt;
  logic [ADDR_W-1:0]   g_rd;
  logic [DATA_W-1:0]   g_data;

  // Combinational grant; forced idle while reset is asserted so no write leaks out.
  always_comb begin
    gnt_a  = 1'b0;
    gnt_b  = 1'b0;
    g_rd   = '0;
    g_data = '0;
    if (rst_n) begin
      gnt_a = a_valid && (!b_valid || (prio_q == PRIO_A));
      gnt_b = b_valid && !gnt_a;
    end
    if (gnt_a) begin
      g_rd   = a_rd;
      g_data = a_data;
    end else if (gnt_b) begin
      g_rd   = b_rd;
      g_data = b_data;
    end
  end

  assign gnt     = gnt_a || gnt_b;
  assign a_ready = gnt_a;
  assign b_ready = gnt_b;
  assign rd      = g_rd;
  assign write_d = g_data;
  assign write_e = gnt && (g_rd != '0);

  // Next state: completing write-back clears busy, a same-cycle allocation re-sets it.
  always_comb begin
    prio_d = prio_q;
    busy_d = busy_q;
    err_d  = err_q;
    if (gnt_a) begin
      prio_d = PRIO_B;
    end else if (gnt_b) begin
      prio_d = PRIO_A;
    end
    if (gnt && (g_rd != '0)) begin
      if (!busy_q[g_rd]) begin
        err_d = 1'b1;
      end
      busy_d[g_rd] = 1'b0;
    end
    if (alloc_v && (alloc_rd != '0)) begin
      busy_d[alloc_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q <= PRIO_A;
      busy_q <= '0;
      err_q  <= 1'b0;
    end else begin
      prio_q <= prio_d;
      busy_q <= busy_d;
      err_q  <= err_d;
    end
  end

  // Stall sees only registered busy: no bypass from a same-cycle write-back.
  assign stall = (busy_q[reg_s1] && (reg_s1 != '0)) ||
                 (busy_q[reg_s2] && (reg_s2 != '0));
  assign busy  = busy_q;
  assign err   = err_q;

endmodule

// File: doc/rf_wb_ctrl.md
# rf_wb_ctrl

Write-back controller for the 32×32 register file `rf`. It shares the single `rf` write port (`rd`/`write_e`/`write_d`) between two write-back requesters: A (ALU) and B (load unit). Arbitration is round-robin. It also keeps a per-register busy scoreboard that the issue stage uses to stall on read-after-write hazards. It sits between the execute/memory stages and `rf`, and drives `rf` write inputs directly.

## Interface
- `NUM_REG`, 32, number of architectural registers; x0 is hard-wired zero.
- `ADDR_W`, 5, register address width; must satisfy 2^ADDR_W = NUM_REG.
- `DATA_W`, 32, write data width.

- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `alloc_v`  in  1  issue stage marks `alloc_rd` as pending (instruction with a destination issued).
- `alloc_rd`  in  ADDR_W  destination register being allocated.
- `a_valid`  in  1  requester A has a write-back.
- `a_rd`  in  ADDR_W  A destination.
- `a_data`  in  DATA_W  A write data.
- `a_ready`  out  1  A write-back accepted this cycle.
- `b_valid`, `b_rd`, `b_data`, `b_ready`: same as A, for requester B.
- `rd`  out  ADDR_W  to `rf.rd`.
- `write_e`  out  1  to `rf.write_e`.
- `write_d`  out  DATA_W  to `rf.write_d`.
- `reg_s1`, `reg_s2`  in  ADDR_W  source registers of the instruction in issue.
- `stall`  out  1  hazard: a source register is busy.
- `busy`  out  NUM_REG  scoreboard vector; bit 0 is always 0.
- `err`  out  1  sticky: a write-back targeted a non-busy register other than x0.

## Operation
- State:
  - `busy[NUM_REG-1:0]`
  - `prio`: 0 = A preferred, 1 = B preferred
  - `err`
- Arbitration is combinational from the current valids and `prio`:
  - Only A valid: grant A.
  - Only B valid: grant B.
  - Both valid: grant the requester `prio` selects.
  - Neither valid: no grant.
- Exactly one `*_ready` is high per grant. A handshake completes when `valid && ready` in the same cycle.
- Requesters hold `rd`/`data` stable while valid and not ready.
- Write port:
  - `rd` and `write_d` come from the granted requester; they are 0 when there is no grant.
  - `write_e` = grant && granted `rd` != 0.
  - A write-back to x0 is accepted (ready=1) but not written.
- `prio` update: on a grant to A, `prio` <= 1; on a grant to B, `prio` <= 0; with no grant it holds.
- Scoreboard, per register r != 0, at each edge:
  - Set if `alloc_v && alloc_rd == r`.
  - Else clear if a handshake completes with granted `rd == r`.
  - Else hold.
  - Simultaneous alloc and clear of the same r: alloc wins and the bit stays set (the new producer is pending).
  - `alloc_v` to x0 is ignored.
  - Allocating an already-busy register is legal (WAW); the bit stays set.
- `stall` = (`busy[reg_s1]` && `reg_s1` != 0) || (`busy[reg_s2]` && `reg_s2` != 0). It is computed from registered `busy`.
- No bypass: a write-back completing in cycle N does not drop `stall` in cycle N. `stall` drops in cycle N+1, when `rf` already holds the value.
- `err` is set on an accepted write-back with `rd` != 0 whose `busy` bit was 0 at that edge. It is cleared only by reset. The write still occurs.

## Timing
- Reset (`rst_n` low, asynchronous):
  - `busy` = 0, `prio` = 0, `err` = 0.
  - While in reset: `a_ready` = `b_ready` = 0, `write_e` = 0, `rd` = 0, `write_d` = 0, `stall` = 0.
- Reset deassertion takes effect at the first rising edge with `rst_n` high.
- Write-back latency is zero cycles at this block: handshake in cycle N → `write_e` high in cycle N → `rf` updates at the end-of-N edge → the value is readable from `rf` in N+1.
- Scoreboard set/clear are visible on `busy`/`stall` one cycle after the edge that samples them.
- Reset mid-operation:
  - Pending allocations are dropped.
  - No write occurs in any cycle with `rst_n` low.
  - A requester held valid through reset is granted after release, starting from `prio` = 0.
- Fairness: with A and B both continuously valid, grants alternate A, B, A, …; neither requester waits more than 1 cycle.

## Test plan
- After reset: alloc x4; A writes 42→x4 in the next cycle → `write_e`=1, `rd`=4, `write_d`=42 that cycle; `busy[4]` 1→0; `rf` x4 reads 42 the following cycle; `err`=0.
- A (x2=99) and B (x5=7) valid together with x2 and x5 allocated → cycle 1 grants A (`b_ready`=0), cycle 2 grants B; `rf` x2=99, x5=7; both busy bits clear.
- A and B held valid for 4 cycles with distinct allocated rds → grant sequence A, B, A, B.
- Alloc x3, then `reg_s1`=3 → `stall`=1. B writes x3 in cycle N → `stall` still 1 in N, 0 in N+1. `reg_s2`=0 never stalls.
- Same-cycle alloc x6 and write-back to x6 (x6 previously busy) → `busy[6]` stays 1. Write-back to non-busy x9 → written, `err`=1 and sticky. A write-back of 5 to x0 → `a_ready`=1, `write_e`=0, x0 reads 0.
- Alloc x7, assert `rst_n`=0 mid-stream with A valid → `write_e`=0 and `busy`=0 during reset. After release, A granted first cycle; `err` cleared; `busy[7]`=0.
